// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Memory-access pipeline stage of the in-order LoongArch core.
//                Waits for the data-SRAM response of a load or store, aligns
//                and extends load data, forwards results to write-back and
//                decode, and discards responses orphaned by a pipeline flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int DROP_W = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        exe_to_mem_valid,
    output logic        mem_allowin,
    input  logic        exe_req_sent,
    input  logic        exe_res_from_mem,
    input  logic [1:0]  exe_size,
    input  logic        exe_load_sign,
    input  logic [31:0] exe_result,
    input  logic        exe_regW,
    input  logic [4:0]  exe_regWAddr,
    input  logic        exe_excp,
    input  logic        exe_ertn,
    input  logic [5:0]  exe_excp_num,
    input  logic [31:0] exe_pc,

    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,

    input  logic        wb_allowin,
    input  logic        wb_flush,
    output logic        mem_to_wb_valid,
    output logic        mem_regW,
    output logic [4:0]  mem_regWAddr,
    output logic        mem_excp,
    output logic        mem_ertn,
    output logic [5:0]  mem_excp_num,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_final_result,

    output logic        mem_to_exe_flush,
    output logic        mem_fwd_valid,
    output logic        mem_fwd_block,
    output logic [31:0] mem_fwd_data
);

    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    // Control state (reset) and latched instruction fields (no reset needed)
    logic              mem_valid;
    logic              wait_data;
    logic              rdata_buf_valid;
    logic [31:0]       rdata_buf;
    logic [DROP_W-1:0] drop_cnt;

    logic              res_from_mem;
    logic [1:0]        size;
    logic              load_sign;
    logic [31:0]       result;
    logic              regw;
    logic [4:0]        regw_addr;
    logic              excp;
    logic              ertn;
    logic [5:0]        excp_num;
    logic [31:0]       pc;

    // Handshake and response qualifiers
    logic        data_ok_live;
    logic        mem_ready_go;
    logic        accept;
    logic        leave;
    logic        capture;
    logic        drop_inc;
    logic        drop_dec;
    logic [31:0] load_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    // A response only belongs to the current instruction once every
    // orphaned response from flushed instructions has drained.
    assign data_ok_live    = data_sram_data_ok & (drop_cnt == '0);
    assign mem_ready_go    = ~wait_data | rdata_buf_valid | data_ok_live;
    assign mem_allowin     = ~mem_valid | (mem_ready_go & wb_allowin);
    assign mem_to_wb_valid = mem_valid & mem_ready_go;
    assign accept          = mem_allowin & exe_to_mem_valid;
    assign leave           = mem_to_wb_valid & wb_allowin;
    assign capture         = mem_valid & wait_data & ~rdata_buf_valid & data_ok_live;
    assign drop_inc        = wb_flush & mem_valid & wait_data & ~data_ok_live;
    assign drop_dec        = data_sram_data_ok & (drop_cnt != '0);

    // Valid bit, outstanding-response flag and buffered-response flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid       <= 1'b0;
            wait_data       <= 1'b0;
            rdata_buf_valid <= 1'b0;
        end else begin
            if (wb_flush) begin
                mem_valid <= 1'b0;
            end else if (mem_allowin) begin
                mem_valid <= exe_to_mem_valid;
            end

            if (accept && !wb_flush) begin
                wait_data <= exe_req_sent;
            end else if (wb_flush || capture) begin
                wait_data <= 1'b0;
            end

            if (wb_flush || leave) begin
                rdata_buf_valid <= 1'b0;
            end else if (capture) begin
                rdata_buf_valid <= 1'b1;
            end
        end
    end

    // Count responses still owed to flushed instructions; saturates at max
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else begin
            unique case ({drop_inc, drop_dec})
                2'b10:   if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 1'b1;
                2'b01:   drop_cnt <= drop_cnt - 1'b1;
                default: drop_cnt <= drop_cnt;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Flag overflow of the drop counter in simulation
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(drop_inc && !drop_dec && drop_cnt == DROP_MAX))
                else $error("mem_stage: drop counter overflow");
        end
    end
`endif

    // Hold the response when WB cannot take the instruction yet
    always_ff @(posedge clk) begin
        if (capture) begin
            rdata_buf <= data_sram_rdata;
        end
    end

    // Latch the execute-stage record on entry
    always_ff @(posedge clk) begin
        if (accept) begin
            res_from_mem <= exe_res_from_mem;
            size         <= exe_size;
            load_sign    <= exe_load_sign;
            result       <= exe_result;
            regw         <= exe_regW;
            regw_addr    <= exe_regWAddr;
            excp         <= exe_excp;
            ertn         <= exe_ertn;
            excp_num     <= exe_excp_num;
            pc           <= exe_pc;
        end
    end

    // Select the lane addressed by the load and extend it to 32 bits
    always_comb begin
        load_word = rdata_buf_valid ? rdata_buf : data_sram_rdata;
        unique case (result[1:0])
            2'b00:   byte_sel = load_word[7:0];
            2'b01:   byte_sel = load_word[15:8];
            2'b10:   byte_sel = load_word[23:16];
            default: byte_sel = load_word[31:24];
        endcase
        half_sel = result[1] ? load_word[31:16] : load_word[15:0];
        unique case (size)
            2'b01:   load_data = {{24{load_sign & byte_sel[7]}}, byte_sel};
            2'b10:   load_data = {{16{load_sign & half_sel[15]}}, half_sel};
            default: load_data = load_word;
        endcase
        mem_final_result = res_from_mem ? load_data : result;
    end

    assign mem_regW         = regw & ~excp;
    assign mem_regWAddr     = regw_addr;
    assign mem_excp         = excp;
    assign mem_ertn         = ertn;
    assign mem_excp_num     = excp_num;
    assign mem_pc           = pc;
    assign mem_to_exe_flush = mem_valid & (excp | ertn);
    assign mem_fwd_valid    = mem_valid;
    assign mem_fwd_block    = mem_valid & res_from_mem & ~mem_ready_go;
    assign mem_fwd_data     = mem_final_result;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Randomized self-checking bench for mem_stage with a
//                transaction-level reference model and an in-order SRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        exe_to_mem_valid;
    logic        mem_allowin;
    logic        exe_req_sent;
    logic        exe_res_from_mem;
    logic [1:0]  exe_size;
    logic        exe_load_sign;
    logic [31:0] exe_result;
    logic        exe_regW;
    logic [4:0]  exe_regWAddr;
    logic        exe_excp;
    logic        exe_ertn;
    logic [5:0]  exe_excp_num;
    logic [31:0] exe_pc;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        wb_allowin;
    logic        wb_flush;
    logic        mem_to_wb_valid;
    logic        mem_regW;
    logic [4:0]  mem_regWAddr;
    logic        mem_excp;
    logic        mem_ertn;
    logic [5:0]  mem_excp_num;
    logic [31:0] mem_pc;
    logic [31:0] mem_final_result;
    logic        mem_to_exe_flush;
    logic        mem_fwd_valid;
    logic        mem_fwd_block;
    logic [31:0] mem_fwd_data;

    mem_stage #(.DROP_W(2)) dut (
        .clk(clk), .reset(reset),
        .exe_to_mem_valid(exe_to_mem_valid), .mem_allowin(mem_allowin),
        .exe_req_sent(exe_req_sent), .exe_res_from_mem(exe_res_from_mem),
        .exe_size(exe_size), .exe_load_sign(exe_load_sign),
        .exe_result(exe_result), .exe_regW(exe_regW),
        .exe_regWAddr(exe_regWAddr), .exe_excp(exe_excp),
        .exe_ertn(exe_ertn), .exe_excp_num(exe_excp_num), .exe_pc(exe_pc),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .wb_allowin(wb_allowin), .wb_flush(wb_flush),
        .mem_to_wb_valid(mem_to_wb_valid), .mem_regW(mem_regW),
        .mem_regWAddr(mem_regWAddr), .mem_excp(mem_excp), .mem_ertn(mem_ertn),
        .mem_excp_num(mem_excp_num), .mem_pc(mem_pc),
        .mem_final_result(mem_final_result), .mem_to_exe_flush(mem_to_exe_flush),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_block(mem_fwd_block),
        .mem_fwd_data(mem_fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        load;
        logic        sign;
        logic [1:0]  size;
        logic [31:0] res;
        logic        regw;
        logic [4:0]  wa;
        logic        excp;
        logic        ertn;
        logic [5:0]  num;
        logic [31:0] pc;
        logic [31:0] rdata;
        int          dly;
    } instr_t;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // Reference model state: what is in MEM and what the SRAM still owes
    logic        in_mem = 1'b0;
    instr_t      cur;
    instr_t      nxt;
    logic        pend = 1'b0;
    logic        resp_got = 1'b0;
    logic [31:0] resp_data = '0;
    int          stale = 0;
    int          last_due = 0;
    int          q_due[$];
    logic [31:0] q_dat[$];
    instr_t      dir[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Load result from the architectural rule: pick the naturally aligned
    // lane of the requested width, then zero- or sign-extend it.
    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [31:0] word,
                                             input logic [1:0] sz, input logic sgn);
        int nb, off, bits;
        logic [31:0] v, m;
        nb   = (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
        off  = int'(addr[1:0]) & ~(nb - 1);
        v    = word >> (8 * off);
        bits = 8 * nb;
        if (bits < 32) begin
            m = (32'h1 << bits) - 32'h1;
            v = v & m;
            if (sgn && v[bits-1]) v = v | ~m;
        end
        return v;
    endfunction

    function automatic instr_t mk(input logic req, input logic load, input logic sgn,
                                  input logic [1:0] sz, input logic [31:0] res,
                                  input logic [31:0] rd, input int dly,
                                  input logic excp, input logic ertn);
        instr_t t;
        t.req = req; t.load = load; t.sign = sgn; t.size = sz; t.res = res;
        t.rdata = rd; t.dly = dly; t.excp = excp; t.ertn = ertn;
        t.regw = 1'($urandom); t.wa = 5'($urandom); t.num = 6'($urandom);
        t.pc = $urandom;
        return t;
    endfunction

    function automatic instr_t gen();
        int kind;
        logic [1:0] sz;
        kind = $urandom_range(0, 7);
        sz   = 2'($urandom_range(1, 3));
        case (kind)
            0:       gen = mk(1'b0, 1'b0, 1'b0, sz, $urandom, $urandom, 0, 1'b1, 1'b0);
            1:       gen = mk(1'b0, 1'b0, 1'b0, sz, $urandom, $urandom, 0, 1'b0, 1'b1);
            2:       gen = mk(1'b0, 1'b0, 1'b0, sz, $urandom, $urandom, 0, 1'b0, 1'b0);
            3:       gen = mk(1'b1, 1'b0, 1'b0, sz, $urandom, $urandom, $urandom_range(0, 3), 1'b0, 1'b0);
            default: gen = mk(1'b1, 1'b1, 1'($urandom), sz, $urandom, $urandom, $urandom_range(0, 3), 1'b0, 1'b0);
        endcase
        if (gen.excp) gen.regw = 1'b1;
    endfunction

    initial begin
        logic        f, dok, live, rdy, e_wb, e_allow, inc, drain;
        logic [31:0] exp_res;
        int          d;

        reset = 1'b1;
        exe_to_mem_valid = 1'b0; exe_req_sent = 1'b0; exe_res_from_mem = 1'b0;
        exe_size = 2'b11; exe_load_sign = 1'b0; exe_result = '0; exe_regW = 1'b0;
        exe_regWAddr = '0; exe_excp = 1'b0; exe_ertn = 1'b0; exe_excp_num = '0;
        exe_pc = '0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        wb_allowin = 1'b1; wb_flush = 1'b0;

        // Reset state, observed before any clock edge
        #1;
        chk("rst_fwd_valid", 32'(mem_fwd_valid), 32'd0);
        chk("rst_to_wb",     32'(mem_to_wb_valid), 32'd0);
        chk("rst_allowin",   32'(mem_allowin), 32'd1);
        chk("rst_block",     32'(mem_fwd_block), 32'd0);
        chk("rst_flush",     32'(mem_to_exe_flush), 32'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Scenario loads first, then random traffic
        dir.push_back(mk(1'b1, 1'b1, 1'b0, 2'b11, 32'h0000_1000, 32'hDEAD_BEEF, 2, 1'b0, 1'b0));
        dir.push_back(mk(1'b1, 1'b1, 1'b1, 2'b01, 32'h0000_1003, 32'h8011_2233, 1, 1'b0, 1'b0));
        dir.push_back(mk(1'b1, 1'b1, 1'b0, 2'b10, 32'h0000_1002, 32'h8011_2233, 0, 1'b0, 1'b0));
        dir.push_back(mk(1'b1, 1'b1, 1'b0, 2'b11, 32'h0000_2000, 32'h1234_5678, 1, 1'b0, 1'b0));
        dir.push_back(mk(1'b0, 1'b0, 1'b0, 2'b11, 32'h0000_0040, 32'h0, 0, 1'b1, 1'b0));

        for (int c = 0; c < 700; c++) begin
            drain = (c >= 600);
            @(negedge clk);
            if (!pend) begin
                if (dir.size() > 0) nxt = dir.pop_front();
                else                nxt = gen();
                pend = 1'b1;
            end
            f = !drain && (stale < 2) && ($urandom_range(0, 19) == 0);
            wb_flush   = f;
            wb_allowin = drain || ($urandom_range(0, 3) != 0);
            exe_to_mem_valid = pend && !f && !drain && ($urandom_range(0, 3) != 0);
            exe_req_sent = nxt.req; exe_res_from_mem = nxt.load; exe_size = nxt.size;
            exe_load_sign = nxt.sign; exe_result = nxt.res; exe_regW = nxt.regw;
            exe_regWAddr = nxt.wa; exe_excp = nxt.excp; exe_ertn = nxt.ertn;
            exe_excp_num = nxt.num; exe_pc = nxt.pc;
            dok = (q_due.size() > 0) && (q_due[0] <= cyc);
            data_sram_data_ok = dok;
            data_sram_rdata   = dok ? q_dat[0] : $urandom;
            #3;

            live    = dok && (stale == 0);
            rdy     = !cur.req || resp_got || live;
            e_wb    = in_mem && rdy;
            e_allow = !in_mem || (rdy && wb_allowin);

            chk("allowin",   32'(mem_allowin), 32'(e_allow));
            chk("to_wb",     32'(mem_to_wb_valid), 32'(e_wb));
            chk("fwd_valid", 32'(mem_fwd_valid), 32'(in_mem));
            chk("fwd_block", 32'(mem_fwd_block), 32'(in_mem && cur.load && !rdy));
            chk("exe_flush", 32'(mem_to_exe_flush), 32'(in_mem && (cur.excp || cur.ertn)));
            if (e_wb) begin
                exp_res = cur.load ? ref_load(cur.res, resp_got ? resp_data : data_sram_rdata,
                                              cur.size, cur.sign)
                                   : cur.res;
                chk("result",   mem_final_result, exp_res);
                chk("fwd_data", mem_fwd_data, exp_res);
                chk("regW",     32'(mem_regW), 32'(cur.regw && !cur.excp));
                chk("regWAddr", 32'(mem_regWAddr), 32'(cur.wa));
                chk("pc",       mem_pc, cur.pc);
                chk("excp_num", 32'(mem_excp_num), 32'(cur.num));
                chk("excp",     32'(mem_excp), 32'(cur.excp));
                chk("ertn",     32'(mem_ertn), 32'(cur.ertn));
            end

            // Advance the reference model across the clock edge
            inc = f && in_mem && cur.req && !resp_got && !live;
            if (dok) begin
                if (stale > 0) begin
                    stale--;
                end else if (in_mem && cur.req && !resp_got) begin
                    resp_got  = 1'b1;
                    resp_data = q_dat[0];
                end
                void'(q_due.pop_front());
                void'(q_dat.pop_front());
            end
            if (inc) stale++;
            if (f) begin
                in_mem = 1'b0;
            end else if (e_allow) begin
                if (exe_to_mem_valid) begin
                    in_mem   = 1'b1;
                    cur      = nxt;
                    pend     = 1'b0;
                    resp_got = 1'b0;
                    if (cur.req) begin
                        d = cyc + 1 + cur.dly;
                        if (d <= last_due) d = last_due + 1;
                        q_due.push_back(d);
                        q_dat.push_back(cur.rdata);
                        last_due = d;
                    end
                end else begin
                    in_mem = 1'b0;
                end
            end
            cyc++;
        end

        chk("drained", 32'(q_due.size()), 32'd0);

        // Reset asserted mid-cycle while a load waits: outputs clear at once
        @(negedge clk);
        wb_flush = 1'b0; wb_allowin = 1'b1; data_sram_data_ok = 1'b0;
        exe_to_mem_valid = 1'b1; exe_req_sent = 1'b1; exe_res_from_mem = 1'b1;
        exe_size = 2'b11; exe_excp = 1'b0; exe_ertn = 1'b0;
        @(negedge clk);
        exe_to_mem_valid = 1'b0;
        #1;
        chk("wait_block", 32'(mem_fwd_block), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_fwd_valid", 32'(mem_fwd_valid), 32'd0);
        chk("arst_block",     32'(mem_fwd_block), 32'd0);
        chk("arst_to_wb",     32'(mem_to_wb_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and the write-back stage of the in-order LoongArch core.
- Accepts execute results plus the record of any data-SRAM request the execute stage issued, and waits for the SRAM response (data_ok).
- Aligns and extends load data, then hands results to write-back.
- Raises the exception/ERTN flush toward execute, supplies RAW-forwarding information to decode, and discards stale responses after a pipeline flush.

Parameters:
- DROP_W, 2, width of the stale-response drop counter (max outstanding dropped responses = 2^DROP_W-1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- exe_to_mem_valid  in  1  execute stage presents an instruction.
- mem_allowin  out  1  MEM can accept this cycle.
- exe_req_sent  in  1  execute issued a data_sram request (addr_ok seen) for this instruction.
- exe_res_from_mem  in  1  instruction is a load.
- exe_size  in  2  01 byte, 10 half, 11 word.
- exe_load_sign  in  1  sign-extend load.
- exe_result  in  32  ALU/mul/div result; memory address for loads and stores.
- exe_regW  in  1  GR write enable.
- exe_regWAddr  in  5  destination GR.
- exe_excp  in  1  exception flagged upstream.
- exe_ertn  in  1  ERTN instruction.
- exe_excp_num  in  6  exception code vector.
- exe_pc  in  32  PC.
- data_sram_data_ok  in  1  SRAM response valid.
- data_sram_rdata  in  32  SRAM read data.
- wb_allowin  in  1  write-back can accept.
- wb_flush  in  1  exception/ERTN committed in WB; kill MEM.
- mem_to_wb_valid  out  1  result valid to WB.
- mem_regW, mem_regWAddr, mem_excp, mem_ertn, mem_excp_num, mem_pc  out  1/5/1/1/6/32  registered copies; mem_regW forced 0 when mem_excp.
- mem_final_result  out  32  load data (aligned/extended) or exe_result.
- mem_to_exe_flush  out  1  mem_valid & (mem_excp | mem_ertn).
- mem_fwd_valid  out  1  mem_valid.
- mem_fwd_block  out  1  mem_valid & load & response not yet received (decode must stall).
- mem_fwd_data  out  32  equals mem_final_result.

Behaviour:
- Reset (async) clears: mem_valid, wait_data, rdata_buf_valid, drop_cnt. All outputs derived from these read 0; data registers are don't-care.
- mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin).
- mem_to_wb_valid = mem_valid & mem_ready_go.
- On clock edge:
  - If wb_flush: mem_valid <= 0.
  - Otherwise, if mem_allowin: mem_valid <= exe_to_mem_valid.
  - On mem_allowin & exe_to_mem_valid: latch all exe_* fields and set wait_data <= exe_req_sent.
- Stores also set wait_data; they wait for data_ok and their result is exe_result.
- mem_ready_go = ~wait_data | rdata_buf_valid | data_ok_live, where data_ok_live = data_sram_data_ok & (drop_cnt == 0).
- Response handling:
  - data_ok_live while wait_data and not buffered: capture rdata into rdata_buf, set rdata_buf_valid, clear wait_data.
  - The same-cycle data uses the bypass path.
  - rdata_buf_valid clears when the instruction leaves (mem_to_wb_valid & wb_allowin) or on wb_flush.
- Load alignment (addr = latched exe_result):
  - Byte: lane addr[1:0].
  - Half: lane addr[1] (upper half if 1).
  - Word: whole word.
  - Extension: sign-extend if load_sign, else zero-extend.
  - Non-load: result passes through unchanged.
- Flush with an outstanding request: if wb_flush while mem_valid & wait_data & ~data_ok_live, then drop_cnt += 1.
- Drop counter: any data_sram_data_ok while drop_cnt != 0 decrements it and is ignored. Increment and decrement in the same cycle leave it unchanged. It saturates at maximum (assertion error in simulation).
- mem_excp instructions never wait (exe_req_sent is 0 for them).
- mem_fwd_block deasserts in the same cycle data_ok_live arrives.

Test Plan:
- ld.w at 0x1000, data_ok 2 cycles after entry, rdata 0xDEADBEEF -> mem_fwd_block=1 for 2 cycles; mem_to_wb_valid with result 0xDEADBEEF in the data_ok cycle.
- ld.b signed addr 0x1003, rdata 0x80112233 -> 0xFFFFFF80; ld.hu addr 0x1002, same rdata -> 0x00008011.
- Load data_ok arrives while wb_allowin=0 for 3 cycles -> data held in buffer; result 0x12345678 delivered once WB allows; no duplicate valid.
- wb_flush while load is waiting, then data_ok with 0xAAAAAAAA, then a new ld.w gets data_ok 0x55555555 -> first response dropped (drop_cnt 1->0); new load's result is 0x55555555.
- Entering instruction with exe_excp=1, regW=1 -> mem_to_exe_flush=1, mem_regW=0, passes in 1 cycle with no wait.
- Assert reset mid-wait -> mem_valid, mem_fwd_block, mem_to_wb_valid all 0 immediately (asynchronously), before the next clock edge.
